pc_unit: RTL

Parametrised program-counter unit for the MIPS CPU front end. It replaces the bare PC register. It adds:
- asynchronous reset to a vector;
- a boot cycle before fetch is valid;
- pipeline stall;
- prioritised redirects (exception, jr, jump, branch);
- a one-entry pending-redirect buffer, so a redirect raised during a stall is not lost.

It feeds the instruction-memory address and the PC+STEP value to the IF stage.

---
 rtl/pc_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program-counter unit for the MIPS front end: boot cycle, stall, prioritised
// redirects and a one-entry buffer that keeps redirects raised during a stall.
module pc_unit #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter logic [31:0] EXC_VECTOR   = 32'h80000180,
    parameter int          STEP         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             exception,
    output logic [WIDTH-1:0] currPC,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] epc,
    output logic             redirect_pending
);

    typedef enum logic {BOOT, RUN} state_t;

    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));
    localparam logic [WIDTH-1:0] RESET_W    = RESET_VECTOR[WIDTH-1:0];
    localparam logic [WIDTH-1:0] EXC_W      = EXC_VECTOR[WIDTH-1:0];

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] epc_reg, epc_next;
    logic [WIDTH-1:0] pend_target_reg, pend_target_next;
    logic             pend_reg, pend_next;
    logic             fetch_valid_reg, fetch_valid_next;
    logic             live_req;
    logic [WIDTH-1:0] live_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_W;
            epc_reg         <= '0;
            pend_target_reg <= '0;
            pend_reg        <= 1'b0;
            fetch_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            epc_reg         <= epc_next;
            pend_target_reg <= pend_target_next;
            pend_reg        <= pend_next;
            fetch_valid_reg <= fetch_valid_next;
        end
    end

    // Highest-priority live request; all loaded targets are word aligned.
    always_comb begin
        live_req = jr | jump | branch_taken;
        if (jr)
            live_target = jr_target & ALIGN_MASK;
        else if (jump)
            live_target = jump_target & ALIGN_MASK;
        else
            live_target = branch_target & ALIGN_MASK;
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        epc_next         = epc_reg;
        pend_target_next = pend_target_reg;
        pend_next        = pend_reg;
        fetch_valid_next = fetch_valid_reg;

        case (state_reg)
            BOOT: begin
                // Only exceptions are honoured while booting; redirects are dropped.
                state_next       = RUN;
                fetch_valid_next = 1'b1;
                if (exception) begin
                    pc_next   = EXC_W;
                    epc_next  = pc_reg;
                    pend_next = 1'b0;
                end
            end
            RUN: begin
                if (exception) begin
                    pc_next   = EXC_W;
                    epc_next  = pc_reg;
                    pend_next = 1'b0;
                end else if (stall) begin
                    if (live_req) begin
                        pend_target_next = live_target;
                        pend_next        = 1'b1;
                    end
                end else if (live_req) begin
                    pc_next   = live_target;
                    pend_next = 1'b0;
                end else if (pend_reg) begin
                    pc_next   = pend_target_reg;
                    pend_next = 1'b0;
                end else begin
                    pc_next = pc_reg + STEP_W;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign currPC           = pc_reg;
    assign pc_plus_step     = pc_reg + STEP_W;
    assign fetch_valid      = fetch_valid_reg;
    assign epc              = epc_reg;
    assign redirect_pending = pend_reg;

endmodule
